lcd_debug_viewer: RTL



---
 rtl/lcd_debug_viewer.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/lcd_debug_viewer.sv
// Debug viewer behind the lcd_module slot scanner: fixed status slots plus a paged
// window onto up to four debug channels, with channel/page/auto-scroll driven by commands.
module lcd_debug_viewer #(
  parameter int          NUM_CH        = 2,
  parameter int          ADDR_W        = 6,
  parameter int          DATA_W        = 32,
  parameter int          WIN           = 32,
  parameter int          SCROLL_CYCLES = 10000000,
  parameter logic [95:0] CH_NAMES      = {24'h0, 24'h0, "REG", "MEM"}
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [5:0]               display_number,
  input  logic                     input_valid,
  input  logic [31:0]              input_value,
  input  logic [31:0]              stat_in,
  output logic [ADDR_W-1:0]        dbg_addr,
  input  logic [NUM_CH*DATA_W-1:0] dbg_rdata,
  output logic                     display_valid,
  output logic [39:0]              display_name,
  output logic [31:0]              display_value,
  output logic [1:0]               cur_ch,
  output logic [7:0]               cur_page
);

  localparam int         DEPTH      = 1 << ADDR_W;
  localparam int         PAGES      = (DEPTH + WIN - 1) / WIN;
  localparam logic [7:0] LAST_PAGE  = 8'(PAGES - 1);
  localparam logic [8:0] PAGES_W    = 9'(PAGES);
  localparam logic [5:0] FIRST_SLOT = 6'd7;
  localparam logic [5:0] LAST_SLOT  = 6'(6 + WIN);
  localparam logic [31:0] TICK_AT   = 32'(SCROLL_CYCLES - 1);

  localparam logic [3:0] OP_SELCH = 4'h1;
  localparam logic [3:0] OP_SETPG = 4'h2;
  localparam logic [3:0] OP_PGUP  = 4'h3;
  localparam logic [3:0] OP_PGDN  = 4'h4;
  localparam logic [3:0] OP_AUTO  = 4'h5;

  logic [1:0]  cur_ch_q, cur_ch_d;
  logic [7:0]  cur_page_q, cur_page_d;
  logic        auto_q, auto_d;
  logic [31:0] cnt_q, cnt_d;

  logic [5:0]  slot_q;
  logic [31:0] idx_q, idx_d;
  logic [1:0]  ch_q;

  logic        valid_q, valid_d;
  logic [39:0] name_q, name_d;
  logic [31:0] value_q, value_d;

  logic [31:0] base;
  logic [7:0]  page_inc, page_dec;
  logic        accept;
  logic [3:0]  op;
  logic        unused_cmd_bits;

  logic [DATA_W-1:0] rd_ch [4];
  logic [23:0]       pfx   [4];

  assign unused_cmd_bits = ^input_value[27:8];

  assign base     = 32'(cur_page_q) * 32'(WIN);
  assign idx_d    = base + 32'(display_number) - 32'd7;
  assign dbg_addr = idx_d[ADDR_W-1:0];

  assign op       = input_value[31:28];
  assign page_inc = (cur_page_q == LAST_PAGE) ? 8'd0 : cur_page_q + 8'd1;
  assign page_dec = (cur_page_q == 8'd0) ? LAST_PAGE : cur_page_q - 8'd1;

  function automatic logic [7:0] hex_ascii(input logic [3:0] d);
    return (d < 4'd10) ? 8'h30 + {4'h0, d} : 8'h37 + {4'h0, d};
  endfunction

  // A command on the same edge as a scroll tick wins and swallows the tick.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch is inferred.
    cur_ch_d   = cur_ch_q;
    cur_page_d = cur_page_q;
    auto_d     = auto_q;
    cnt_d      = cnt_q;
    accept     = 1'b0;
    if (input_valid) begin
      case (op)
        OP_SELCH: if ({1'b0, input_value[1:0]} < 3'(NUM_CH)) begin
          accept     = 1'b1;
          cur_ch_d   = input_value[1:0];
          cur_page_d = 8'd0;
        end
        OP_SETPG: if ({1'b0, input_value[7:0]} < PAGES_W) begin
          accept     = 1'b1;
          cur_page_d = input_value[7:0];
        end
        OP_PGUP: begin accept = 1'b1; cur_page_d = page_inc; end
        OP_PGDN: begin accept = 1'b1; cur_page_d = page_dec; end
        OP_AUTO: begin accept = 1'b1; auto_d = input_value[0]; end
        default: ;
      endcase
    end
    if (accept) begin
      cnt_d = 32'd0;
    end else if (auto_q) begin
      if (cnt_q == TICK_AT) begin
        cnt_d      = 32'd0;
        cur_page_d = page_inc;
      end else begin
        cnt_d = cnt_q + 32'd1;
      end
    end else begin
      cnt_d = 32'd0;
    end
  end

  always_comb begin
    for (int c = 0; c < 4; c++) begin
      rd_ch[c] = '0;
      pfx[c]   = CH_NAMES[c*24 +: 24];
    end
    for (int c = 0; c < NUM_CH; c++) rd_ch[c] = dbg_rdata[c*DATA_W +: DATA_W];
  end

  always_comb begin
    valid_d = 1'b0;
    name_d  = '0;
    value_d = '0;
    case (slot_q)
      6'd1: begin valid_d = 1'b1; name_d = "CHAN "; value_d = 32'(cur_ch_q);   end
      6'd2: begin valid_d = 1'b1; name_d = "PAGE "; value_d = 32'(cur_page_q); end
      6'd3: begin valid_d = 1'b1; name_d = "PAGES"; value_d = 32'(PAGES);      end
      6'd4: begin valid_d = 1'b1; name_d = "BASE "; value_d = base;            end
      6'd5: begin valid_d = 1'b1; name_d = "AUTO "; value_d = 32'(auto_q);     end
      6'd6: begin valid_d = 1'b1; name_d = "STAT "; value_d = stat_in;         end
      default: begin
        // Slots past DEPTH on a partial last page stay blank.
        if (slot_q >= FIRST_SLOT && slot_q <= LAST_SLOT && idx_q < 32'(DEPTH)) begin
          valid_d                = 1'b1;
          name_d                 = {pfx[ch_q], hex_ascii(idx_q[7:4]), hex_ascii(idx_q[3:0])};
          value_d[DATA_W-1:0]    = rd_ch[ch_q];
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cur_ch_q   <= 2'd0;
      cur_page_q <= 8'd0;
      auto_q     <= 1'b0;
      cnt_q      <= 32'd0;
      slot_q     <= 6'd0;
      idx_q      <= 32'd0;
      ch_q       <= 2'd0;
      valid_q    <= 1'b0;
      name_q     <= '0;
      value_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments let every register see pre-edge values.
      cur_ch_q   <= cur_ch_d;
      cur_page_q <= cur_page_d;
      auto_q     <= auto_d;
      cnt_q      <= cnt_d;
      slot_q     <= display_number;
      idx_q      <= idx_d;
      ch_q       <= cur_ch_q;
      valid_q    <= valid_d;
      name_q     <= name_d;
      value_q    <= value_d;
    end
  end

  assign display_valid = valid_q;
  assign display_name  = name_q;
  assign display_value = value_q;
  assign cur_ch        = cur_ch_q;
  assign cur_page      = cur_page_q;

endmodule
